// File: rtl/uart_rx_frame_if.sv
// Handshake/bus bundle for the framed serial receiver.
// Signals:
//   tick_serial        - synchronised serial line (idles high), into the receiver
//   tick_ready         - consumer accepts the buffered word this cycle
//   get_valid_ret      - output buffer holds an unconsumed word
//   get_data_out_ret   - buffered word
//   get_frame_err_ret  - buffered word had a stop bit sampled low
//   get_parity_err_ret - buffered word failed its parity check
//   get_overrun_ret    - sticky: a completed frame was dropped (buffer full)
//   get_checksum_ret   - running 32-bit sum of clean committed words
// Modports: slave = receiver side, master = line driver / consumer side.
interface uart_rx_frame_if #(
  parameter int data_bits = 8
);
  logic                 tick_serial;
  logic                 tick_ready;
  logic                 get_valid_ret;
  logic [data_bits-1:0] get_data_out_ret;
  logic                 get_frame_err_ret;
  logic                 get_parity_err_ret;
  logic                 get_overrun_ret;
  logic [31:0]          get_checksum_ret;

  modport slave (
    input  tick_serial,
    input  tick_ready,
    output get_valid_ret,
    output get_data_out_ret,
    output get_frame_err_ret,
    output get_parity_err_ret,
    output get_overrun_ret,
    output get_checksum_ret
  );

  modport master (
    output tick_serial,
    output tick_ready,
    input  get_valid_ret,
    input  get_data_out_ret,
    input  get_frame_err_ret,
    input  get_parity_err_ret,
    input  get_overrun_ret,
    input  get_checksum_ret
  );
endinterface

// File: rtl/uart_rx_frame.sv
// Parametrised serial frame receiver: start / data (LSB first) / optional
// parity / one or two stop bits, mid-bit sampling, glitch rejection of the
// start bit, one-entry output buffer with valid/ready and a running checksum.
// Ports:
//   clock      - rising-edge clock
//   tick_reset - synchronous active-high reset
//   rx         - uart_rx_frame_if.slave (serial in, ready in, buffer/status out)
module uart_rx_frame #(
  parameter int cycles_per_bit = 4,
  parameter int data_bits      = 8,
  parameter int parity_mode    = 0,
  parameter int stop_bits      = 1
) (
  input  logic             clock,
  input  logic             tick_reset,
  uart_rx_frame_if.slave   rx
);
  localparam int half  = cycles_per_bit / 2;
  // The IDLE cycle that detects the falling edge already counts as the first
  // cycle of the half-bit wait, so START needs one cycle fewer.
  localparam int start_wait = (half > 1) ? (half - 2) : 0;
  localparam int dly_w = $clog2(cycles_per_bit);
  localparam int cnt_w = $clog2(data_bits + 1);

  localparam logic [dly_w-1:0] start_last = dly_w'(start_wait);
  localparam logic [dly_w-1:0] bit_last   = dly_w'(cycles_per_bit - 1);
  localparam logic [cnt_w-1:0] data_last  = cnt_w'(data_bits - 1);
  localparam logic [cnt_w-1:0] stop_last  = cnt_w'(stop_bits - 1);
  localparam logic             odd_parity = (parity_mode == 2);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } state_t;

  state_t               state_r, state_s;
  logic [dly_w-1:0]     delay_r, delay_s;
  logic [cnt_w-1:0]     bit_cnt_r, bit_cnt_s;
  logic [data_bits-1:0] shift_r, shift_s;
  logic                 acc_frame_err_r, acc_frame_err_s;
  logic                 acc_parity_err_r, acc_parity_err_s;
  logic                 commit_s;

  logic                 valid_r;
  logic [data_bits-1:0] data_r;
  logic                 buf_frame_err_r;
  logic                 buf_parity_err_r;
  logic                 overrun_r;
  logic [31:0]          checksum_r;

  // Parity is bad when data^parity bit does not give the expected polarity.
  function automatic logic parity_bad(input logic [data_bits-1:0] word,
                                      input logic bit_in, input logic odd);
    return ((^word) ^ bit_in) != odd;
  endfunction

  // Receive FSM: next state, counters, shift register and commit strobe.
  always_comb begin
    state_s          = state_r;
    delay_s          = delay_r;
    bit_cnt_s        = bit_cnt_r;
    shift_s          = shift_r;
    acc_frame_err_s  = acc_frame_err_r;
    acc_parity_err_s = acc_parity_err_r;
    commit_s         = 1'b0;
    case (state_r)
      IDLE: begin
        delay_s          = '0;
        bit_cnt_s        = '0;
        acc_frame_err_s  = 1'b0;
        acc_parity_err_s = 1'b0;
        if (!rx.tick_serial) begin
          state_s = START;
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        if (delay_r == start_last) begin
          delay_s = '0;
          if (rx.tick_serial) begin
            state_s = IDLE;  // line came back high: glitch
          end else begin
            state_s = DATA;
          end
        end else begin
          delay_s = delay_r + dly_w'(1);
        end
      end
      DATA: begin
        if (delay_r == bit_last) begin
          delay_s = '0;
          shift_s = {rx.tick_serial, shift_r[data_bits-1:1]};
          if (bit_cnt_r == data_last) begin
            bit_cnt_s = '0;
            state_s   = (parity_mode != 0) ? PARITY : STOP;
          end else begin
            bit_cnt_s = bit_cnt_r + cnt_w'(1);
          end
        end else begin
          delay_s = delay_r + dly_w'(1);
        end
      end
      PARITY: begin
        if (delay_r == bit_last) begin
          delay_s          = '0;
          acc_parity_err_s = parity_bad(shift_r, rx.tick_serial, odd_parity);
          state_s          = STOP;
        end else begin
          delay_s = delay_r + dly_w'(1);
        end
      end
      STOP: begin
        if (delay_r == bit_last) begin
          delay_s = '0;
          if (!rx.tick_serial) begin
            acc_frame_err_s = 1'b1;
          end else begin
            acc_frame_err_s = acc_frame_err_r;
          end
          if (bit_cnt_r == stop_last) begin
            commit_s  = 1'b1;
            bit_cnt_s = '0;
            // A low stop bit may be a break; wait for the line to recover.
            state_s   = acc_frame_err_s ? WAIT_HIGH : IDLE;
          end else begin
            bit_cnt_s = bit_cnt_r + cnt_w'(1);
          end
        end else begin
          delay_s = delay_r + dly_w'(1);
        end
      end
      WAIT_HIGH: begin
        if (rx.tick_serial) begin
          state_s = IDLE;
        end else begin
          state_s = WAIT_HIGH;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Receive FSM state and datapath registers.
  always_ff @(posedge clock) begin
    if (tick_reset) begin
      state_r          <= IDLE;
      delay_r          <= '0;
      bit_cnt_r        <= '0;
      shift_r          <= '0;
      acc_frame_err_r  <= 1'b0;
      acc_parity_err_r <= 1'b0;
    end else begin
      state_r          <= state_s;
      delay_r          <= delay_s;
      bit_cnt_r        <= bit_cnt_s;
      shift_r          <= shift_s;
      acc_frame_err_r  <= acc_frame_err_s;
      acc_parity_err_r <= acc_parity_err_s;
    end
  end

  // Output buffer, overrun flag and checksum.
  always_ff @(posedge clock) begin
    if (tick_reset) begin
      valid_r          <= 1'b0;
      data_r           <= '0;
      buf_frame_err_r  <= 1'b0;
      buf_parity_err_r <= 1'b0;
      overrun_r        <= 1'b0;
      checksum_r       <= 32'd0;
    end else if (commit_s && (!valid_r || rx.tick_ready)) begin
      valid_r          <= 1'b1;
      data_r           <= shift_r;
      buf_frame_err_r  <= acc_frame_err_s;
      buf_parity_err_r <= acc_parity_err_s;
      if (!acc_frame_err_s && !acc_parity_err_s) begin
        checksum_r <= checksum_r + 32'(shift_r);
      end else begin
        checksum_r <= checksum_r;
      end
    end else if (commit_s) begin
      overrun_r <= 1'b1;  // buffer full and not being drained: drop frame
    end else if (valid_r && rx.tick_ready) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

  assign rx.get_valid_ret      = valid_r;
  assign rx.get_data_out_ret   = data_r;
  assign rx.get_frame_err_ret  = buf_frame_err_r;
  assign rx.get_parity_err_ret = buf_parity_err_r;
  assign rx.get_overrun_ret    = overrun_r;
  assign rx.get_checksum_ret   = checksum_r;
endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: three instances (8n1, 8e1, 8n2) at 4 cycles/bit.
module tb_uart_rx_frame;
  localparam int CPB = 4;

  logic        clock = 1'b0;
  logic        tick_reset;
  logic [2:0]  ser;
  logic [2:0]  rdy;
  wire  [2:0]  vld;
  wire  [2:0]  fe;
  wire  [2:0]  pe;
  wire  [2:0]  ov;
  wire  [7:0]  dat [3];
  wire  [31:0] chk [3];

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    uart_rx_frame_if #(.data_bits(8)) bus ();
    assign bus.tick_serial = ser[g];
    assign bus.tick_ready  = rdy[g];
    assign vld[g] = bus.get_valid_ret;
    assign dat[g] = bus.get_data_out_ret;
    assign fe[g]  = bus.get_frame_err_ret;
    assign pe[g]  = bus.get_parity_err_ret;
    assign ov[g]  = bus.get_overrun_ret;
    assign chk[g] = bus.get_checksum_ret;
    uart_rx_frame #(
      .cycles_per_bit(CPB),
      .data_bits(8),
      .parity_mode((g == 1) ? 1 : 0),
      .stop_bits((g == 2) ? 2 : 1)
    ) dut (
      .clock(clock),
      .tick_reset(tick_reset),
      .rx(bus)
    );
  end

  typedef struct {
    int          k;
    logic [7:0]  word;
    logic        par;
    logic        s1;
    logic        s2;
    logic [7:0]  exp_data;
    logic        exp_pe;
    logic        exp_fe;
    logic [31:0] exp_chk;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic drive_bit(input int k, input logic b);
    ser[k] = b;
    repeat (CPB) @(negedge clock);
  endtask

  // Start, 8 data bits LSB first, parity (instance 1), stop(s).
  task automatic send_frame(input int k, input logic [7:0] word, input logic par,
                            input logic s1, input logic s2);
    drive_bit(k, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(k, word[i]);
    if (k == 1) drive_bit(k, par);
    drive_bit(k, s1);
    if (k == 2) drive_bit(k, s2);
  endtask

  task automatic check_word(input int k, input string tag, input logic [7:0] d,
                            input logic p, input logic f, input logic o,
                            input logic [31:0] c);
    check({tag, ".valid"},   32'(vld[k]), 32'd1);
    check({tag, ".data"},    32'(dat[k]), 32'(d));
    check({tag, ".par_err"}, 32'(pe[k]),  32'(p));
    check({tag, ".frm_err"}, 32'(fe[k]),  32'(f));
    check({tag, ".overrun"}, 32'(ov[k]),  32'(o));
    check({tag, ".checksum"}, chk[k], c);
  endtask

  task automatic consume(input int k, input string tag);
    rdy[k] = 1'b1;
    @(negedge clock);
    rdy[k] = 1'b0;
    check({tag, ".drained"}, 32'(vld[k]), 32'd0);
  endtask

  task automatic check_zero(input int k, input string tag);
    check({tag, ".valid"},    32'(vld[k]), 32'd0);
    check({tag, ".data"},     32'(dat[k]), 32'd0);
    check({tag, ".par_err"},  32'(pe[k]),  32'd0);
    check({tag, ".frm_err"},  32'(fe[k]),  32'd0);
    check({tag, ".overrun"},  32'(ov[k]),  32'd0);
    check({tag, ".checksum"}, chk[k],      32'd0);
  endtask

  initial begin
    //          k  word   par   s1    s2    data   pe    fe    checksum
    vecs[0] = '{0, 8'hA5, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 32'h0000_00A5};
    vecs[1] = '{0, 8'h5A, 1'b0, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b0, 32'h0000_00FF};
    vecs[2] = '{1, 8'h07, 1'b0, 1'b1, 1'b1, 8'h07, 1'b1, 1'b0, 32'h0000_0000};
    vecs[3] = '{1, 8'h07, 1'b1, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0, 32'h0000_0007};
    vecs[4] = '{1, 8'h00, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 32'h0000_0007};
    vecs[5] = '{1, 8'hFF, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 32'h0000_0007};
    vecs[6] = '{0, 8'h80, 1'b0, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1, 32'h0000_00FF};
    vecs[7] = '{2, 8'h33, 1'b0, 1'b1, 1'b1, 8'h33, 1'b0, 1'b0, 32'h0000_0033};

    tick_reset = 1'b1;
    ser = 3'b111;
    rdy = 3'b000;
    repeat (3) @(negedge clock);
    for (int k = 0; k < 3; k++) check_zero(k, $sformatf("reset%0d", k));
    tick_reset = 1'b0;
    @(negedge clock);

    // Table-driven frames on all three configurations.
    for (int v = 0; v < 8; v++) begin
      send_frame(vecs[v].k, vecs[v].word, vecs[v].par, vecs[v].s1, vecs[v].s2);
      check_word(vecs[v].k, $sformatf("vec%0d", v), vecs[v].exp_data,
                 vecs[v].exp_pe, vecs[v].exp_fe, 1'b0, vecs[v].exp_chk);
      consume(vecs[v].k, $sformatf("vec%0d", v));
      drive_bit(vecs[v].k, 1'b1);
    end

    // One-cycle low pulse is rejected; a clean frame afterwards is received.
    ser[0] = 1'b0;
    @(negedge clock);
    ser[0] = 1'b1;
    repeat (12) @(negedge clock);
    check("glitch.no_valid", 32'(vld[0]), 32'd0);
    send_frame(0, 8'h3C, 1'b0, 1'b1, 1'b1);
    check_word(0, "after_glitch", 8'h3C, 1'b0, 1'b0, 1'b0, 32'h0000_013B);
    consume(0, "after_glitch");

    // Second stop bit low then a held-low line: exactly one errored frame.
    send_frame(2, 8'h44, 1'b0, 1'b1, 1'b0);
    check_word(2, "break", 8'h44, 1'b0, 1'b1, 1'b0, 32'h0000_0033);
    consume(2, "break");
    repeat (50) @(negedge clock);
    check("break.no_repeat", 32'(vld[2]), 32'd0);
    drive_bit(2, 1'b1);
    send_frame(2, 8'h55, 1'b0, 1'b1, 1'b1);
    check_word(2, "after_break", 8'h55, 1'b0, 1'b0, 1'b0, 32'h0000_0088);
    consume(2, "after_break");

    // Ready asserted exactly in the commit cycle of a second frame.
    send_frame(0, 8'h66, 1'b0, 1'b1, 1'b1);
    check_word(0, "first66", 8'h66, 1'b0, 1'b0, 1'b0, 32'h0000_01A1);
    drive_bit(0, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(0, 1'(8'h77 >> i));
    ser[0] = 1'b1;
    @(negedge clock);
    rdy[0] = 1'b1;
    @(negedge clock);
    rdy[0] = 1'b0;
    repeat (2) @(negedge clock);
    check_word(0, "commit_ready", 8'h77, 1'b0, 1'b0, 1'b0, 32'h0000_0218);
    consume(0, "commit_ready");

    // Back-to-back frames with no ready: second is dropped, overrun sticks.
    send_frame(0, 8'h11, 1'b0, 1'b1, 1'b1);
    send_frame(0, 8'h22, 1'b0, 1'b1, 1'b1);
    check_word(0, "overrun", 8'h11, 1'b0, 1'b0, 1'b1, 32'h0000_0229);
    consume(0, "overrun");
    check("overrun.sticky", 32'(ov[0]), 32'd1);

    // Reset in the middle of DATA abandons the frame.
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b1);
    drive_bit(0, 1'b0);
    tick_reset = 1'b1;
    ser = 3'b111;
    @(negedge clock);
    tick_reset = 1'b0;
    check_zero(0, "mid_reset");
    repeat (8) @(negedge clock);
    send_frame(0, 8'h5C, 1'b0, 1'b1, 1'b1);
    check_word(0, "after_reset", 8'h5C, 1'b0, 1'b0, 1'b0, 32'h0000_005C);
    consume(0, "after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx_frame.md
Name: uart_rx_frame

Overview:
Parametrised successor to the fixed 8n1 serial receiver. Supports configurable data width, optional even/odd parity and one or two stop bits. Samples each bit at mid-bit, rejects glitched start bits, and flags framing, parity and overrun errors. The received word is held in a one-entry output buffer with a valid/ready handshake, and a running checksum covers clean frames. It sits between the serial pin synchroniser and the byte consumer (FIFO or command parser).

Parameters:
cycles_per_bit, 4, clock cycles per serial bit; legal values are >= 2.
data_bits, 8, data bits per frame; legal range 5..9; sent LSB first.
parity_mode, 0, 0 = none, 1 = even, 2 = odd.
stop_bits, 1, number of stop bits; legal values 1 or 2.

Ports:
clock  input  1  global clock; all state updates on the rising edge.
tick_reset  input  1  synchronous reset, active-high.
tick_serial  input  1  serial line, already synchronised; idles high.
tick_ready  input  1  consumer accepts the buffered word this cycle.
get_valid_ret  output  1  output buffer holds an unconsumed word.
get_data_out_ret  output  data_bits  buffered word.
get_frame_err_ret  output  1  buffered word had a stop bit sampled low.
get_parity_err_ret  output  1  buffered word failed the parity check; always 0 when parity_mode = 0.
get_overrun_ret  output  1  sticky: a completed frame was dropped because the buffer was full.
get_checksum_ret  output  32  modulo-2^32 sum of all error-free committed words, zero-extended.

Behaviour:
- Reset: state IDLE, counters 0, shift register 0. Every output reads 0 in the cycle after reset is sampled high. Reset mid-frame abandons the frame with no commit.
- half = cycles_per_bit/2 (integer division). Bit counter width is $clog2(data_bits+1). Delay counter width is $clog2(cycles_per_bit).
- IDLE: when tick_serial is sampled 0, go to START with delay = 0.
- START: count up to half-1, then sample. If the sample is 1, treat it as a glitch and return to IDLE. If it is 0, go to DATA with delay reset.
- DATA: sample each bit every cycles_per_bit cycles after the previous sample. Shift the bit into the MSB of a data_bits-wide register, shifting right. After data_bits samples, go to PARITY if parity_mode != 0, otherwise go to STOP.
- PARITY: one sample. Error if (XOR of data bits XOR sampled bit) != (parity_mode == 2).
- STOP: take stop_bits samples. Any sample of 0 sets frame_err.
- Commit happens in the cycle of the final stop sample; registered outputs update on the next edge.
  - If the buffer is empty, or tick_ready is high that cycle, write data and error flags and set valid.
  - If the buffer is full and tick_ready is low, drop the new frame, leave the buffer unchanged and set overrun.
- Checksum: on a successful commit with both error flags clear, add the word to the checksum. Dropped and errored frames do not contribute.
- Exit from STOP:
  - After a clean stop, return to IDLE.
  - After a frame error, go to WAIT_HIGH and stay until tick_serial is sampled 1, then go to IDLE. This prevents a break condition from generating repeated frames.
- Handshake: with valid=1 and tick_ready=1, valid drops next cycle unless a commit occurs in the same cycle. tick_ready with valid=0 is ignored.
- The error flags belong to the buffered word and are replaced on each commit. Overrun clears only on reset.
- The receiver never stalls. Serial reception continues regardless of tick_ready.

Test Plan:
- cycles_per_bit=4, 8n1; line goes low at cycle 0; send 0xA5. Start is sampled at cycle 1, data at 5..33, stop at 37. Required: valid=1 at cycle 38, data=0xA5, both error flags 0, checksum 0x000000A5.
- Low pulse of 1 cycle in IDLE (shorter than half) -> no valid, state back to IDLE. A clean 0x3C sent afterwards is received correctly.
- parity_mode=1; send 0x07 with parity bit 0 (wrong) -> valid=1, data=0x07, parity_err=1, checksum unchanged. Resend with parity 1 -> parity_err=0, checksum +7.
- stop_bits=2; second stop bit held low, then line low for 50 cycles -> exactly one frame with frame_err=1. No new frame until the line returns high and a fresh start arrives.
- Two back-to-back frames 0x11 then 0x22 with tick_ready=0 -> data stays 0x11 and overrun=1. Raise tick_ready -> valid drops; checksum 0x11.
- tick_ready asserted in the exact commit cycle of a second frame -> valid stays 1, data becomes the new word, overrun=0. Reset asserted mid-DATA -> all outputs 0, next frame received cleanly.
